matvec_address_sequencer: RTL and testbench

Parametrised address and control sequencer for the matrix-vector multiply datapath. It computes y = W·x for a ROWS×COLS weight matrix W (row-major in the weight buffer) and a COLS-entry input vector x. Each pass covers LANES rows in parallel. For every row group it drives weight and input read addresses, MAC clear, accumulate-enable and valid strobes, and per-lane output write addresses and enables. It sits between the weight/input/output buffers and the LANES MAC units. Compared with the fixed 8×8, 4-lane generator, it adds:

- independent ROWS, COLS and LANES;
- a partial final row group;
- a start/busy/done handshake;
- an accumulate-stall input;
- asynchronous reset.

---
 rtl/matvec_address_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_matvec_address_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matvec_address_sequencer.sv
// matvec_address_sequencer
// Address and control sequencer for a LANES-wide matrix-vector MAC array.
// It walks the row groups of a ROWS x COLS row-major weight matrix. For each
// group it issues a MAC clear, then COLS accumulate beats (weight and input
// read addresses), then a valid strobe, then a per-lane output write. The
// whole pass is framed by a start/busy/done handshake.
// All outputs except acc_en come straight from flops. acc_en is gated by the
// live hold input, so a stalled beat is never counted by the MACs.
`timescale 1ns/1ps

module matvec_address_sequencer #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int LANES       = 4,
  parameter int W_ADDR_BITS = 6,
  parameter int X_ADDR_BITS = 3,
  parameter int Y_ADDR_BITS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           hold,
  output logic                           busy,
  output logic                           done,
  output logic                           clear,
  output logic                           acc_en,
  output logic                           valid,
  output logic [LANES*W_ADDR_BITS-1:0]   w_addr,
  output logic [X_ADDR_BITS-1:0]         x_addr,
  output logic [LANES*Y_ADDR_BITS-1:0]   y_addr,
  output logic [LANES-1:0]               lane_en,
  output logic [LANES-1:0]               lane_we
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The row base can reach ROWS-1+LANES before the end-of-pass compare, so it
  // gets one spare bit and never wraps.
  localparam int RBW = $clog2(ROWS + LANES) + 1;
  localparam int CW  = $clog2(COLS) + 1;
  // Width for address arithmetic. It holds any in-range product and is wide
  // enough that every cast below only truncates or extends.
  localparam int PW  = max2(max2($clog2(ROWS * COLS) + 1, RBW),
                            max2(max2(CW, W_ADDR_BITS), Y_ADDR_BITS));

  localparam logic [RBW-1:0] ROWS_R   = RBW'(ROWS);
  localparam logic [RBW-1:0] LANES_R  = RBW'(LANES);
  localparam logic [CW-1:0]  COL_LAST = CW'(COLS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Weight address for lane k: (row_base + k) * COLS + col.
  function automatic logic [W_ADDR_BITS-1:0] w_addr_of(input logic [RBW-1:0] rb,
                                                       input int             k,
                                                       input logic [CW-1:0]  c);
    logic [PW-1:0] row;
    logic [PW-1:0] prod;
    row  = PW'(rb) + PW'(k);
    prod = row * PW'(COLS) + PW'(c);
    return W_ADDR_BITS'(prod);
  endfunction

  // Output address for lane k: row_base + k.
  function automatic logic [Y_ADDR_BITS-1:0] y_addr_of(input logic [RBW-1:0] rb,
                                                       input int             k);
    logic [PW-1:0] row;
    row = PW'(rb) + PW'(k);
    return Y_ADDR_BITS'(row);
  endfunction

  logic [2:0]                 state_q, state_d;
  logic [RBW-1:0]             row_q, row_d;
  logic [CW-1:0]              col_q, col_d;

  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       clear_q, clear_d;
  logic                       acc_ph_q, acc_ph_d;
  logic                       valid_q, valid_d;
  logic [LANES*W_ADDR_BITS-1:0] w_addr_q, w_addr_d;
  logic [X_ADDR_BITS-1:0]     x_addr_q, x_addr_d;
  logic [LANES*Y_ADDR_BITS-1:0] y_addr_q, y_addr_d;
  logic [LANES-1:0]           lane_en_q, lane_en_d;
  logic [LANES-1:0]           lane_we_q, lane_we_d;
  logic [LANES-1:0]           act_d;

  // Phase sequencing, row-group stepping and column stepping (hold freezes ACCUM).
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_CLEAR: state_d = S_ACCUM;
      S_ACCUM: begin
        if (!hold) begin
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = S_VALID;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_VALID: state_d = S_WRITE;
      S_WRITE: begin
        row_d   = row_q + LANES_R;
        state_d = (row_d >= ROWS_R) ? S_DONE : S_CLEAR;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Decode the outputs for the coming cycle, so that every strobe and address leaves a flop.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    clear_d  = (state_d == S_CLEAR);
    acc_ph_d = (state_d == S_ACCUM);
    valid_d  = (state_d == S_VALID);

    act_d = '0;
    for (int k = 0; k < LANES; k++) begin
      act_d[k] = ((row_d + RBW'(k)) < ROWS_R);
    end

    // Lane mask is latched on entry to CLEAR and carried unchanged through WRITE.
    lane_en_d = '0;
    if (state_d == S_CLEAR) begin
      lane_en_d = act_d;
    end else if (state_d inside {S_ACCUM, S_VALID, S_WRITE}) begin
      lane_en_d = lane_en_q;
    end

    lane_we_d = (state_d == S_WRITE) ? lane_en_d : '0;
    x_addr_d  = acc_ph_d ? X_ADDR_BITS'(col_d) : '0;

    w_addr_d = '0;
    y_addr_d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (acc_ph_d && lane_en_d[k]) begin
        w_addr_d[k*W_ADDR_BITS +: W_ADDR_BITS] = w_addr_of(row_d, k, col_d);
      end
      if ((valid_d || (state_d == S_WRITE)) && lane_en_d[k]) begin
        y_addr_d[k*Y_ADDR_BITS +: Y_ADDR_BITS] = y_addr_of(row_d, k);
      end
    end
  end

  // State, counters and registered outputs; reset forces IDLE and all-zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clear_q   <= 1'b0;
      acc_ph_q  <= 1'b0;
      valid_q   <= 1'b0;
      w_addr_q  <= '0;
      x_addr_q  <= '0;
      y_addr_q  <= '0;
      lane_en_q <= '0;
      lane_we_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clear_q   <= clear_d;
      acc_ph_q  <= acc_ph_d;
      valid_q   <= valid_d;
      w_addr_q  <= w_addr_d;
      x_addr_q  <= x_addr_d;
      y_addr_q  <= y_addr_d;
      lane_en_q <= lane_en_d;
      lane_we_q <= lane_we_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign clear   = clear_q;
  assign acc_en  = acc_ph_q & ~hold;
  assign valid   = valid_q;
  assign w_addr  = w_addr_q;
  assign x_addr  = x_addr_q;
  assign y_addr  = y_addr_q;
  assign lane_en = lane_en_q;
  assign lane_we = lane_we_q;

endmodule

// File: tb/tb_matvec_address_sequencer.sv
// Testbench for matvec_address_sequencer: four parameterisations, directed
// checkpoint table, hold/restart/reset sequences and random start/hold
// against a beat-queue reference model.
`timescale 1ns/1ps

module tb_matvec_address_sequencer;

  typedef enum int {P_IDLE, P_CLEAR, P_ACC, P_VALID, P_WRITE, P_DONE} ph_t;
  typedef struct {ph_t ph; int rb; int col;} beat_t;
  typedef struct {int r; int c; int l; int wb; int xb; int yb;} cfg_t;
  typedef struct packed {
    logic        busy;
    logic        done;
    logic        clear;
    logic        acc_en;
    logic        valid;
    logic [7:0]  lane_en;
    logic [7:0]  lane_we;
    logic [31:0] w_addr;
    logic [15:0] x_addr;
    logic [31:0] y_addr;
  } obs_t;
  typedef struct {int sel; int cyc; int sig; longint val; string nm;} vec_t;

  localparam int F_BUSY = 0, F_DONE = 1, F_CLEAR = 2, F_ACC = 3, F_VALID = 4;
  localparam int F_W = 5, F_X = 6, F_Y = 7, F_LE = 8, F_LW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_s [4];
  logic hold_s  [4];

  logic busy_a, done_a, clear_a, acc_a, valid_a;
  logic [23:0] w_a; logic [2:0] x_a; logic [11:0] y_a; logic [3:0] le_a, lw_a;
  logic busy_b, done_b, clear_b, acc_b, valid_b;
  logic [19:0] w_b; logic [1:0] x_b; logic [11:0] y_b; logic [3:0] le_b, lw_b;
  logic busy_c, done_c, clear_c, acc_c, valid_c;
  logic [15:0] w_c; logic [1:0] x_c; logic [7:0] y_c; logic [3:0] le_c, lw_c;
  logic busy_d, done_d, clear_d, acc_d, valid_d;
  logic [0:0] w_d; logic [0:0] x_d; logic [0:0] y_d; logic [0:0] le_d, lw_d;

  always #5 clk = ~clk;

  matvec_address_sequencer #(.ROWS(8), .COLS(8), .LANES(4), .W_ADDR_BITS(6),
                             .X_ADDR_BITS(3), .Y_ADDR_BITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .hold(hold_s[0]),
    .busy(busy_a), .done(done_a), .clear(clear_a), .acc_en(acc_a), .valid(valid_a),
    .w_addr(w_a), .x_addr(x_a), .y_addr(y_a), .lane_en(le_a), .lane_we(lw_a));

  matvec_address_sequencer #(.ROWS(6), .COLS(3), .LANES(4), .W_ADDR_BITS(5),
                             .X_ADDR_BITS(2), .Y_ADDR_BITS(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .hold(hold_s[1]),
    .busy(busy_b), .done(done_b), .clear(clear_b), .acc_en(acc_b), .valid(valid_b),
    .w_addr(w_b), .x_addr(x_b), .y_addr(y_b), .lane_en(le_b), .lane_we(lw_b));

  matvec_address_sequencer #(.ROWS(4), .COLS(4), .LANES(4), .W_ADDR_BITS(4),
                             .X_ADDR_BITS(2), .Y_ADDR_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .hold(hold_s[2]),
    .busy(busy_c), .done(done_c), .clear(clear_c), .acc_en(acc_c), .valid(valid_c),
    .w_addr(w_c), .x_addr(x_c), .y_addr(y_c), .lane_en(le_c), .lane_we(lw_c));

  matvec_address_sequencer #(.ROWS(1), .COLS(1), .LANES(1), .W_ADDR_BITS(1),
                             .X_ADDR_BITS(1), .Y_ADDR_BITS(1)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .hold(hold_s[3]),
    .busy(busy_d), .done(done_d), .clear(clear_d), .acc_en(acc_d), .valid(valid_d),
    .w_addr(w_d), .x_addr(x_d), .y_addr(y_d), .lane_en(le_d), .lane_we(lw_d));

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cnum  = 0;
  cfg_t  cfgs [4];
  beat_t q [$];
  obs_t  tr [4][0:255];
  vec_t  vecs [$];

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    o = '0;
    case (sel)
      0: begin o.busy = busy_a; o.done = done_a; o.clear = clear_a; o.acc_en = acc_a;
               o.valid = valid_a; o.w_addr = 32'(w_a); o.x_addr = 16'(x_a);
               o.y_addr = 32'(y_a); o.lane_en = 8'(le_a); o.lane_we = 8'(lw_a); end
      1: begin o.busy = busy_b; o.done = done_b; o.clear = clear_b; o.acc_en = acc_b;
               o.valid = valid_b; o.w_addr = 32'(w_b); o.x_addr = 16'(x_b);
               o.y_addr = 32'(y_b); o.lane_en = 8'(le_b); o.lane_we = 8'(lw_b); end
      2: begin o.busy = busy_c; o.done = done_c; o.clear = clear_c; o.acc_en = acc_c;
               o.valid = valid_c; o.w_addr = 32'(w_c); o.x_addr = 16'(x_c);
               o.y_addr = 32'(y_c); o.lane_en = 8'(le_c); o.lane_we = 8'(lw_c); end
      default: begin o.busy = busy_d; o.done = done_d; o.clear = clear_d; o.acc_en = acc_d;
               o.valid = valid_d; o.w_addr = 32'(w_d); o.x_addr = 16'(x_d);
               o.y_addr = 32'(y_d); o.lane_en = 8'(le_d); o.lane_we = 8'(lw_d); end
    endcase
    return o;
  endfunction

  // Expected outputs for one beat of a run, straight from the row/column arithmetic.
  function automatic obs_t exp_obs(input cfg_t c, input beat_t b, input logic hd);
    obs_t o;
    longint v;
    o = '0;
    if (b.ph == P_IDLE) return o;
    o.busy  = 1'b1;
    o.done  = (b.ph == P_DONE);
    o.clear = (b.ph == P_CLEAR);
    o.valid = (b.ph == P_VALID);
    for (int k = 0; k < c.l; k++) begin
      if (b.ph != P_DONE && (b.rb + k) < c.r) begin
        o.lane_en[k] = 1'b1;
        if (b.ph == P_ACC) begin
          v = longint'(((b.rb + k) * c.c + b.col) % (1 << c.wb));
          o.w_addr = o.w_addr | 32'(v << (k * c.wb));
        end
        if (b.ph == P_VALID || b.ph == P_WRITE) begin
          v = longint'((b.rb + k) % (1 << c.yb));
          o.y_addr = o.y_addr | 32'(v << (k * c.yb));
        end
      end
    end
    if (b.ph == P_ACC) begin
      o.acc_en = !hd;
      o.x_addr = 16'(b.col);
    end
    if (b.ph == P_WRITE) o.lane_we = o.lane_en;
    return o;
  endfunction

  task automatic build_run(input cfg_t c);
    for (int rb = 0; rb < c.r; rb += c.l) begin
      q.push_back('{P_CLEAR, rb, 0});
      for (int col = 0; col < c.c; col++) q.push_back('{P_ACC, rb, col});
      q.push_back('{P_VALID, rb, 0});
      q.push_back('{P_WRITE, rb, 0});
    end
    q.push_back('{P_DONE, 0, 0});
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_obs(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %p expected %p", nm, cnum, act, exp);
    end
  endtask

  function automatic longint fld(input obs_t o, input int id);
    case (id)
      F_BUSY:  return longint'(o.busy);
      F_DONE:  return longint'(o.done);
      F_CLEAR: return longint'(o.clear);
      F_ACC:   return longint'(o.acc_en);
      F_VALID: return longint'(o.valid);
      F_W:     return longint'(o.w_addr);
      F_X:     return longint'(o.x_addr);
      F_Y:     return longint'(o.y_addr);
      F_LE:    return longint'(o.lane_en);
      F_LW:    return longint'(o.lane_we);
      default: return -1;
    endcase
  endfunction

  // One clock cycle on DUT sel: drive, sample, compare to model, then advance the model.
  task automatic cyc(input int sel, input logic st, input logic hd);
    beat_t cur;
    obs_t  act;
    cur = (q.size() > 0) ? q[0] : beat_t'{P_IDLE, 0, 0};
    for (int i = 0; i < 4; i++) begin
      start_s[i] = (i == sel) ? st : 1'b0;
      hold_s[i]  = (i == sel) ? hd : 1'b0;
    end
    #1;
    act = get_obs(sel);
    if (cnum < 256) tr[sel][cnum] = act;
    chk_obs($sformatf("model_dut%0d", sel), act, exp_obs(cfgs[sel], cur, hd));
    cnum++;
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      if (st) build_run(cfgs[sel]);
    end else if (!(cur.ph == P_ACC && hd)) begin
      void'(q.pop_front());
    end
  endtask

  task automatic drain(input int sel);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 1000) begin
      cyc(sel, 1'b0, 1'b0);
      guard++;
    end
    chk($sformatf("drain_dut%0d", sel), longint'(q.size()), 0);
  endtask

  task automatic addv(input int sel, input int c, input int sig, input longint val, input string nm);
    vecs.push_back('{sel, c, sig, val, nm});
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cnt;
    int done_at;
    for (int i = 0; i < 4; i++) begin
      start_s[i] = 1'b0;
      hold_s[i]  = 1'b0;
    end
    cfgs[0] = '{r:8, c:8, l:4, wb:6, xb:3, yb:3};
    cfgs[1] = '{r:6, c:3, l:4, wb:5, xb:2, yb:3};
    cfgs[2] = '{r:4, c:4, l:4, wb:4, xb:2, yb:2};
    cfgs[3] = '{r:1, c:1, l:1, wb:1, xb:1, yb:1};

    // Checkpoints: {dut, cycle after start (start in cycle 0), field, value}.
    addv(0, 0,  F_BUSY,  0, "A_busy_c0");
    addv(0, 1,  F_CLEAR, 1, "A_clear_c1");
    addv(0, 1,  F_BUSY,  1, "A_busy_c1");
    addv(0, 2,  F_ACC,   1, "A_acc_c2");
    addv(0, 9,  F_X,     7, "A_x_c9");
    addv(0, 10, F_VALID, 1, "A_valid_c10");
    addv(0, 11, F_LW,    15, "A_we_c11");
    addv(0, 12, F_CLEAR, 1, "A_clear_c12");
    addv(0, 18, F_W,     37 | (45 << 6) | (53 << 12) | (61 << 18), "A_w_g1_col5");
    addv(0, 20, F_X,     7, "A_x_c20");
    addv(0, 21, F_Y,     4 | (5 << 3) | (6 << 6) | (7 << 9), "A_y_c21");
    addv(0, 22, F_LW,    15, "A_we_c22");
    addv(0, 22, F_Y,     4 | (5 << 3) | (6 << 6) | (7 << 9), "A_y_c22");
    addv(0, 23, F_DONE,  1, "A_done_c23");
    addv(0, 23, F_BUSY,  1, "A_busy_c23");
    addv(0, 24, F_BUSY,  0, "A_busy_c24");
    addv(0, 24, F_DONE,  0, "A_done_c24");
    addv(1, 1,  F_LE,    15, "B_le_g0");
    addv(1, 7,  F_LE,    3, "B_le_g1");
    addv(1, 8,  F_W,     12 | (15 << 5), "B_w_g1_col0");
    addv(1, 10, F_W,     14 | (17 << 5), "B_w_g1_col2");
    addv(1, 11, F_Y,     4 | (5 << 3), "B_y_c11");
    addv(1, 12, F_LW,    3, "B_we_c12");
    addv(1, 12, F_Y,     4 | (5 << 3), "B_y_c12");
    addv(1, 13, F_DONE,  1, "B_done_c13");
    addv(1, 12, F_DONE,  0, "B_done_c12");
    addv(3, 1,  F_CLEAR, 1, "D_clear_c1");
    addv(3, 2,  F_ACC,   1, "D_acc_c2");
    addv(3, 2,  F_W,     0, "D_w_c2");
    addv(3, 3,  F_VALID, 1, "D_valid_c3");
    addv(3, 4,  F_LW,    1, "D_we_c4");
    addv(3, 4,  F_Y,     0, "D_y_c4");
    addv(3, 5,  F_DONE,  1, "D_done_c5");
    addv(3, 6,  F_BUSY,  0, "D_busy_c6");

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 4; s++) chk_obs($sformatf("reset_dut%0d", s), get_obs(s), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single runs on A, B, D
    cnum = 0; for (int c = 0; c < 31; c++) cyc(0, c == 0, 1'b0); drain(0);
    cnum = 0; for (int c = 0; c < 20; c++) cyc(1, c == 0, 1'b0); drain(1);
    cnum = 0; for (int c = 0; c < 10; c++) cyc(3, c == 0, 1'b0); drain(3);

    foreach (vecs[i]) chk(vecs[i].nm, fld(tr[vecs[i].sel][vecs[i].cyc], vecs[i].sig), vecs[i].val);

    // Hold for 3 cycles on C while col=2 is presented
    cnum = 0;
    for (int c = 0; c < 16; c++) cyc(2, c == 0, (c >= 4 && c <= 6));
    drain(2);
    acc_cnt = 0;
    done_at = -1;
    for (int c = 0; c < 16; c++) begin
      if (tr[2][c].acc_en) acc_cnt++;
      if (tr[2][c].done && done_at < 0) done_at = c;
    end
    for (int c = 4; c <= 7; c++) chk($sformatf("C_x_stuck_c%0d", c), longint'(tr[2][c].x_addr), 2);
    for (int c = 4; c <= 6; c++) chk($sformatf("C_acc_low_c%0d", c), longint'(tr[2][c].acc_en), 0);
    chk("C_acc_c7", longint'(tr[2][7].acc_en), 1);
    chk("C_acc_count", longint'(acc_cnt), 4);
    chk("C_done_cycle", longint'(done_at), 8 + 3);

    // start held high throughout: no restart until one IDLE cycle after done
    cnum = 0;
    for (int c = 0; c < 40; c++) cyc(0, 1'b1, 1'b0);
    drain(0);
    chk("A_cont_done_c23", longint'(tr[0][23].done), 1);
    chk("A_cont_clear_c12", longint'(tr[0][12].clear), 1);
    chk("A_cont_busy_c24", longint'(tr[0][24].busy), 0);
    chk("A_cont_clear_c25", longint'(tr[0][25].clear), 1);

    // Asynchronous reset in ACCUM of the second row group on A
    cnum = 0;
    for (int c = 0; c < 15; c++) cyc(0, c == 0, 1'b0);
    chk("A_pre_reset_x", longint'(get_obs(0).x_addr), 2);
    rst_n = 1'b0;
    #1;
    chk_obs("A_async_reset", get_obs(0), '0);
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    for (int c = 0; c < 3; c++) cyc(0, 1'b0, 1'b0);
    cnum = 0;
    for (int c = 0; c < 13; c++) cyc(0, c == 0, 1'b0);
    drain(0);
    chk("A_restart_clear", longint'(tr[0][1].clear), 1);
    chk("A_restart_w", longint'(tr[0][2].w_addr), 0 | (8 << 6) | (16 << 12) | (24 << 18));

    // Random start/hold against the model
    for (int s = 0; s < 3; s++) begin
      cnum = 0;
      for (int c = 0; c < 2500; c++)
        cyc(s, ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      drain(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
